av_test_slave_bank: RTL and testbench

Parametrised Avalon-MM simulation slave used to exercise interconnect, arbiter and master logic. It provides a bank of NUM_REGS byte-enabled scratch registers plus two read-only transaction counters. Separate read and write wait-state counts are configurable. Reads are pipelined with a fixed latency and signalled by readdatavalid. The block sits on a decoded peripheral-select slot of the 30-bit word-address Avalon bus.

---
 rtl/av_test_slave_bank.sv | 173 +++++++++++++++++
 tb/tb_av_test_slave_bank.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/av_test_slave_bank.sv
// av_test_slave_bank: Avalon-MM simulation slave with a bank of byte-enabled
// scratch registers and two read-only transaction counters. It decodes one
// peripheral-select slot, inserts configurable read and write wait states,
// and returns read data through a fixed-latency pipeline.
module av_test_slave_bank #(
    parameter int          NUM_PERIPH_SEL_BITS = 5,
    parameter int          PERIPH_SEL          = 0,
    parameter int          NUM_REGS            = 4,
    parameter int          WRITE_WAIT_CYCLES   = 0,
    parameter int          READ_WAIT_CYCLES    = 0,
    parameter int          READ_LATENCY        = 1,
    parameter logic [31:0] BAD_DATA            = 32'hDEADBEEF
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [29:0] i_AV_Addr,
    input  logic [3:0]  i_AV_ByteEn,
    input  logic        i_AV_Read,
    input  logic        i_AV_Write,
    input  logic [31:0] i_AV_WriteData,
    output logic [31:0] o_AV_ReadData,
    output logic        o_AV_ReadDataValid,
    output logic        o_AV_WaitRequest
);

    // Register address width: whatever the slot-select bits leave over.
    localparam int RA_W     = 30 - NUM_PERIPH_SEL_BITS;
    localparam int MAX_WAIT = (WRITE_WAIT_CYCLES > READ_WAIT_CYCLES) ?
                              WRITE_WAIT_CYCLES : READ_WAIT_CYCLES;
    localparam int WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [NUM_PERIPH_SEL_BITS-1:0] SLOT = NUM_PERIPH_SEL_BITS'(PERIPH_SEL);
    localparam logic [RA_W-1:0]   WR_CNT_ADDR = RA_W'(NUM_REGS);
    localparam logic [RA_W-1:0]   RD_CNT_ADDR = RA_W'(NUM_REGS + 1);
    localparam logic [WAIT_W-1:0] WR_WAIT_N   = WAIT_W'(WRITE_WAIT_CYCLES);
    localparam logic [WAIT_W-1:0] RD_WAIT_N   = WAIT_W'(READ_WAIT_CYCLES);

    // Decode and command qualification
    logic              sel;
    logic [RA_W-1:0]   reg_addr;
    logic              cmd;
    logic              is_write;
    logic              wait_req;
    logic              wr_accept;
    logic              rd_accept;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_target;

    // Register bank, counters and read path
    logic [31:0]             regs [NUM_REGS];
    logic [31:0]             wr_count;
    logic [31:0]             rd_count;
    logic                    clr_wr;
    logic                    clr_rd;
    logic [31:0]             rd_mux;
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [31:0]             pipe_dat [READ_LATENCY];

    assign sel      = (i_AV_Addr[29 -: NUM_PERIPH_SEL_BITS] == SLOT);
    assign reg_addr = i_AV_Addr[RA_W-1:0];
    assign cmd      = sel & (i_AV_Read | i_AV_Write);
    // A simultaneous read and write is handled as a write only.
    assign is_write = i_AV_Write;

    assign wait_target      = is_write ? WR_WAIT_N : RD_WAIT_N;
    assign wait_req         = cmd & (wait_cnt != wait_target);
    assign o_AV_WaitRequest = wait_req;

    assign wr_accept = cmd & ~wait_req & is_write;
    assign rd_accept = cmd & ~wait_req & ~is_write;

    // Counter clears need at least one byte lane enabled.
    assign clr_wr = wr_accept & (reg_addr == WR_CNT_ADDR) & (|i_AV_ByteEn);
    assign clr_rd = wr_accept & (reg_addr == RD_CNT_ADDR) & (|i_AV_ByteEn);

    // Wait-state counter: counts stalled cycles of the presented command.
    always_ff @(posedge i_Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (i_Rst) begin
            wait_cnt <= '0;
        end else if (!cmd || !wait_req) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Scratch register bank with per-byte write enables.
    always_ff @(posedge i_Clk) begin
        // NOTE: this bank is small and must read 0 after reset, so it is
        // built from resettable flops rather than a RAM macro.
        if (i_Rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_accept) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_addr == RA_W'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (i_AV_ByteEn[b]) begin
                            regs[i][8*b +: 8] <= i_AV_WriteData[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Accepted-write counter; a clear wins over the same-cycle increment.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            wr_count <= '0;
        end else if (clr_wr) begin
            wr_count <= '0;
        end else if (wr_accept) begin
            wr_count <= wr_count + 32'd1;
        end
    end

    // Accepted-read counter; cleared by a write to its address.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            rd_count <= '0;
        end else if (clr_rd) begin
            rd_count <= '0;
        end else if (rd_accept) begin
            rd_count <= rd_count + 32'd1;
        end
    end

    // Read data mux: snapshot of the addressed location at acceptance.
    always_comb begin
        // NOTE: default first so every path assigns rd_mux and no latch forms.
        rd_mux = BAD_DATA;
        if (reg_addr == WR_CNT_ADDR) begin
            rd_mux = wr_count;
        end else if (reg_addr == RD_CNT_ADDR) begin
            rd_mux = rd_count;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_addr == RA_W'(i)) begin
                rd_mux = regs[i];
            end
        end
    end

    // Read return pipeline; data stages only advance behind a valid so the
    // output holds the last returned word between valid strobes.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_accept;
            if (rd_accept) begin
                pipe_dat[0] <= rd_mux;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                end
            end
        end
    end

    assign o_AV_ReadDataValid = pipe_vld[READ_LATENCY-1];
    assign o_AV_ReadData      = pipe_dat[READ_LATENCY-1];

endmodule

// File: tb/tb_av_test_slave_bank.sv
// tb_av_test_slave_bank: directed bench for av_test_slave_bank. Three
// instances share one input bus: defaults (inst 0), three write wait states
// (inst 1) and read latency three (inst 2). Each test resets the bank first
// where it needs a known starting state.
module tb_av_test_slave_bank;

    logic        clk;
    logic        rst;
    logic [29:0] addr;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;

    logic [31:0] rdata_d, rdata_w, rdata_l;
    logic        vld_d, vld_w, vld_l;
    logic        wait_d, wait_w, wait_l;

    int n_checks;
    int n_fails;

    av_test_slave_bank u_def (
        .i_Clk(clk), .i_Rst(rst), .i_AV_Addr(addr), .i_AV_ByteEn(be),
        .i_AV_Read(rd), .i_AV_Write(wr), .i_AV_WriteData(wdata),
        .o_AV_ReadData(rdata_d), .o_AV_ReadDataValid(vld_d), .o_AV_WaitRequest(wait_d)
    );

    av_test_slave_bank #(.WRITE_WAIT_CYCLES(3)) u_ww (
        .i_Clk(clk), .i_Rst(rst), .i_AV_Addr(addr), .i_AV_ByteEn(be),
        .i_AV_Read(rd), .i_AV_Write(wr), .i_AV_WriteData(wdata),
        .o_AV_ReadData(rdata_w), .o_AV_ReadDataValid(vld_w), .o_AV_WaitRequest(wait_w)
    );

    av_test_slave_bank #(.READ_LATENCY(3)) u_lat (
        .i_Clk(clk), .i_Rst(rst), .i_AV_Addr(addr), .i_AV_ByteEn(be),
        .i_AV_Read(rd), .i_AV_Write(wr), .i_AV_WriteData(wdata),
        .o_AV_ReadData(rdata_l), .o_AV_ReadDataValid(vld_l), .o_AV_WaitRequest(wait_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] get_rdata(input int inst);
        case (inst)
            0:       return rdata_d;
            1:       return rdata_w;
            default: return rdata_l;
        endcase
    endfunction

    function automatic logic get_vld(input int inst);
        case (inst)
            0:       return vld_d;
            1:       return vld_w;
            default: return vld_l;
        endcase
    endfunction

    function automatic logic get_wait(input int inst);
        case (inst)
            0:       return wait_d;
            1:       return wait_w;
            default: return wait_l;
        endcase
    endfunction

    // Tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Holds a write until accepted (bounded); returns the stall count.
    task automatic bus_write(input int inst, input logic [29:0] a, input logic [31:0] d,
                             input logic [3:0] b, output int waits);
        addr = a; wdata = d; be = b; wr = 1'b1; rd = 1'b0;
        waits = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (!get_wait(inst)) break;
            waits++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    // Single read presented for one cycle; returns data and the number of
    // cycles from acceptance to the valid strobe, or 0 when no valid arrives.
    task automatic bus_read(input int inst, input logic [29:0] a,
                            output logic [31:0] d, output int lat);
        addr = a; be = 4'hF; rd = 1'b1; wr = 1'b0;
        @(posedge clk); #1;
        rd = 1'b0;
        lat = 0;
        d = 'x;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (get_vld(inst)) begin
                lat = c;
                d = get_rdata(inst);
                break;
            end
            @(posedge clk); #1;
        end
        if (lat != 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int lat;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (get_rdata(i) !== 32'h0 || get_vld(i) !== 1'b0 || get_wait(i) !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_outputs inst%0d: rdata=%h vld=%b wait=%b, required 0/0/0",
                         i, get_rdata(i), get_vld(i), get_wait(i));
            end
        end
        @(posedge clk); #1;
        bus_read(0, 30'd4, d, lat);
        n_checks++;
        if (d !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_wrcount: got %h, required 00000000", d);
        end
    endtask

    task automatic test_byte_write();
        do_reset();
        addr = 30'd0; be = 4'b0101; wdata = 32'h11223344; wr = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wait_d !== 1'b0) begin
            n_fails++;
            $display("FAIL bw_write_wait: got %b, required 0", wait_d);
        end
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b1; be = 4'hF; addr = 30'd0;
        @(negedge clk);
        n_checks++;
        if (wait_d !== 1'b0 || vld_d !== 1'b0) begin
            n_fails++;
            $display("FAIL bw_read_issue: wait=%b vld=%b, required 0/0", wait_d, vld_d);
        end
        @(posedge clk); #1;
        rd = 1'b0;
        @(negedge clk);
        n_checks++;
        if (vld_d !== 1'b1 || rdata_d !== 32'h00220044) begin
            n_fails++;
            $display("FAIL bw_readback: vld=%b data=%h, required 1/00220044", vld_d, rdata_d);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (vld_d !== 1'b0 || rdata_d !== 32'h00220044) begin
            n_fails++;
            $display("FAIL bw_hold: vld=%b data=%h, required 0/00220044", vld_d, rdata_d);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_wait();
        logic [31:0] d;
        int lat;
        int w;
        do_reset();
        bus_write(1, 30'd1, 32'hCAFEF00D, 4'hF, w);
        n_checks++;
        if (w !== 3) begin
            n_fails++;
            $display("FAIL ww_stall_cycles: got %0d, required 3", w);
        end
        bus_read(1, 30'd1, d, lat);
        n_checks++;
        if (d !== 32'hCAFEF00D || lat !== 1) begin
            n_fails++;
            $display("FAIL ww_readback: data=%h lat=%0d, required CAFEF00D/1", d, lat);
        end
        bus_read(1, 30'd4, d, lat);
        n_checks++;
        if (d !== 32'h1) begin
            n_fails++;
            $display("FAIL ww_wrcount: got %h, required 00000001", d);
        end
    endtask

    task automatic test_pipelined();
        logic [31:0] d;
        logic        exp_v;
        int lat;
        int w;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus_write(2, 30'(i), 32'hA0 + 32'(i), 4'hF, w);
            n_checks++;
            if (w !== 0) begin
                n_fails++;
                $display("FAIL pipe_preload_wait reg%0d: got %0d, required 0", i, w);
            end
        end
        for (int t = 0; t < 8; t++) begin
            if (t < 4) begin
                rd = 1'b1; addr = 30'(t); be = 4'hF;
            end else begin
                rd = 1'b0;
            end
            @(negedge clk);
            exp_v = (t >= 3 && t <= 6);
            n_checks++;
            if (vld_l !== exp_v || (exp_v && rdata_l !== 32'hA0 + 32'(t - 3))) begin
                n_fails++;
                $display("FAIL pipe_cycle%0d: vld=%b data=%h, required vld=%b data=%h",
                         t, vld_l, rdata_l, exp_v, 32'hA0 + 32'(t - 3));
            end
            @(posedge clk); #1;
        end
        bus_read(2, 30'd5, d, lat);
        n_checks++;
        if (d !== 32'h4 || lat !== 3) begin
            n_fails++;
            $display("FAIL pipe_rdcount: data=%h lat=%0d, required 00000004/3", d, lat);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        int lat;
        int w;
        do_reset();
        bus_write(0, 30'd0, 32'h12345678, 4'hF, w);
        bus_read(0, 30'd9, d, lat);
        n_checks++;
        if (d !== 32'hDEADBEEF || lat !== 1) begin
            n_fails++;
            $display("FAIL unmapped_read: data=%h lat=%0d, required DEADBEEF/1", d, lat);
        end
        bus_write(0, 30'd9, 32'hFFFFFFFF, 4'hF, w);
        bus_read(0, 30'd0, d, lat);
        n_checks++;
        if (d !== 32'h12345678) begin
            n_fails++;
            $display("FAIL unmapped_reg0: got %h, required 12345678", d);
        end
        bus_read(0, 30'd3, d, lat);
        n_checks++;
        if (d !== 32'h0) begin
            n_fails++;
            $display("FAIL unmapped_reg3: got %h, required 00000000", d);
        end
        bus_read(0, 30'd4, d, lat);
        n_checks++;
        if (d !== 32'h2) begin
            n_fails++;
            $display("FAIL unmapped_wrcount: got %h, required 00000002", d);
        end
        bus_read(0, 30'd5, d, lat);
        n_checks++;
        if (d !== 32'h4) begin
            n_fails++;
            $display("FAIL unmapped_rdcount: got %h, required 00000004", d);
        end
    endtask

    // Continues from test_unmapped: WrCount=2, RdCount=5.
    task automatic test_counter_clear();
        logic [31:0] d;
        int lat;
        int w;
        bus_write(0, 30'd4, 32'h0, 4'hF, w);
        bus_read(0, 30'd4, d, lat);
        n_checks++;
        if (d !== 32'h0) begin
            n_fails++;
            $display("FAIL clr_wrcount: got %h, required 00000000", d);
        end
        bus_write(0, 30'd4, 32'h0, 4'b0000, w);
        bus_read(0, 30'd4, d, lat);
        n_checks++;
        if (d !== 32'h1) begin
            n_fails++;
            $display("FAIL clr_no_byteen: got %h, required 00000001", d);
        end
        bus_write(0, 30'd5, 32'h0, 4'b0001, w);
        bus_read(0, 30'd5, d, lat);
        n_checks++;
        if (d !== 32'h0) begin
            n_fails++;
            $display("FAIL clr_rdcount: got %h, required 00000000", d);
        end
    endtask

    // Continues from test_counter_clear: WrCount=2, RdCount=1, reg0=12345678.
    task automatic test_slot_decode();
        logic [31:0] d;
        int lat;
        addr = {5'd1, 25'd0}; wdata = 32'hFFFFFFFF; be = 4'hF; wr = 1'b1; rd = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (wait_d !== 1'b0 || wait_w !== 1'b0) begin
                n_fails++;
                $display("FAIL slot_write_wait c%0d: def=%b ww=%b, required 0/0", c, wait_d, wait_w);
            end
            @(posedge clk); #1;
        end
        wr = 1'b0; rd = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (vld_d !== 1'b0 || wait_d !== 1'b0) begin
                n_fails++;
                $display("FAIL slot_read c%0d: vld=%b wait=%b, required 0/0", c, vld_d, wait_d);
            end
            @(posedge clk); #1;
        end
        rd = 1'b0;
        bus_read(0, 30'd0, d, lat);
        n_checks++;
        if (d !== 32'h12345678) begin
            n_fails++;
            $display("FAIL slot_reg0: got %h, required 12345678", d);
        end
        bus_read(0, 30'd4, d, lat);
        n_checks++;
        if (d !== 32'h2) begin
            n_fails++;
            $display("FAIL slot_wrcount: got %h, required 00000002", d);
        end
        bus_read(0, 30'd5, d, lat);
        n_checks++;
        if (d !== 32'h3) begin
            n_fails++;
            $display("FAIL slot_rdcount: got %h, required 00000003", d);
        end
    endtask

    task automatic test_rw_priority();
        logic [31:0] d;
        int lat;
        do_reset();
        addr = 30'd1; wdata = 32'h0BADF00D; be = 4'hF; rd = 1'b1; wr = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (vld_d !== 1'b0) begin
            n_fails++;
            $display("FAIL rw_no_valid: got %b, required 0", vld_d);
        end
        @(posedge clk); #1;
        bus_read(0, 30'd1, d, lat);
        n_checks++;
        if (d !== 32'h0BADF00D) begin
            n_fails++;
            $display("FAIL rw_reg1: got %h, required 0BADF00D", d);
        end
        bus_read(0, 30'd4, d, lat);
        n_checks++;
        if (d !== 32'h1) begin
            n_fails++;
            $display("FAIL rw_wrcount: got %h, required 00000001", d);
        end
        bus_read(0, 30'd5, d, lat);
        n_checks++;
        if (d !== 32'h2) begin
            n_fails++;
            $display("FAIL rw_rdcount: got %h, required 00000002", d);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d;
        int lat;
        int w;
        do_reset();
        bus_write(2, 30'd0, 32'h55, 4'hF, w);
        bus_read(2, 30'd0, d, lat);
        n_checks++;
        if (d !== 32'h55 || lat !== 3) begin
            n_fails++;
            $display("FAIL mid_preread: data=%h lat=%0d, required 00000055/3", d, lat);
        end
        addr = 30'd0; be = 4'hF; rd = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rd = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (vld_l !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_rst_cycle: vld=%b, required 0", vld_l);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (vld_l !== 1'b0 || rdata_l !== 32'h0) begin
                n_fails++;
                $display("FAIL mid_after_rst c%0d: vld=%b data=%h, required 0/00000000",
                         c, vld_l, rdata_l);
            end
            @(posedge clk); #1;
        end
        bus_read(2, 30'd5, d, lat);
        n_checks++;
        if (d !== 32'h0) begin
            n_fails++;
            $display("FAIL mid_rdcount: got %h, required 00000000", d);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wdata = '0;
        test_reset();
        test_byte_write();
        test_write_wait();
        test_pipelined();
        test_unmapped();
        test_counter_clear();
        test_slot_decode();
        test_rw_priority();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
